// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// fault causes and the illegal-width decode.
package lsu_ctrl_pkg;

  localparam int LSU_ADDR_W = 12;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SW_WR = 3'd2,
    ST_RMW   = 3'd3,
    ST_ERR   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    FLT_NONE  = 2'd0,
    FLT_MIS   = 2'd1,
    FLT_RANGE = 2'd2,
    FLT_ILL   = 2'd3
  } fault_e;

  // Stores only know B/H/W; loads additionally accept the unsigned B/H codes.
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    if (we) return !(funct3 inside {F3_B, F3_H, F3_W});
    else    return  (funct3 inside {3'b011, 3'b110, 3'b111});
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Bundle of the execute-stage request/response signals and the word-RAM port.
// master = core + RAM side, slave = the load/store unit.
interface lsu_ctrl_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [1:0]  fault;
  logic [31:0] ram_addr;
  logic        ram_wr_sig;
  logic [31:0] ram_wr_data;
  logic [31:0] ram_rd_data;

  modport master (
    output req, we, funct3, addr, wdata, ram_rd_data,
    input  busy, done, rdata, fault, ram_addr, ram_wr_sig, ram_wr_data
  );

  modport slave (
    input  req, we, funct3, addr, wdata, ram_rd_data,
    output busy, done, rdata, fault, ram_addr, ram_wr_sig, ram_wr_data
  );
endinterface

// File: rtl/lsu_ctrl_align.sv
// Combinational datapath of the LSU: fault decode, load lane extract/extend
// and sub-word store merge into the old RAM word.
module lsu_ctrl_align
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W
) (
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_rd_word,
  input  logic [31:0] i_wdata,
  output fault_e      o_fault,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);

  logic        w_illegal;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic [31:0] w_shifted;

  assign w_illegal      = is_illegal(i_we, i_funct3);
  assign w_misaligned   = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                          ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
  assign w_out_of_range = |i_addr[31:ADDR_W];

  // Only the highest-priority cause is reported.
  always_comb begin
    if (w_illegal)           o_fault = FLT_ILL;
    else if (w_misaligned)   o_fault = FLT_MIS;
    else if (w_out_of_range) o_fault = FLT_RANGE;
    else                     o_fault = FLT_NONE;
  end

  assign w_shifted = i_rd_word >> {i_addr[1:0], 3'b000};

  always_comb begin
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
      F3_H:    o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_BU:   o_load_data = {24'h0, w_shifted[7:0]};
      F3_HU:   o_load_data = {16'h0, w_shifted[15:0]};
      default: o_load_data = w_shifted;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    o_merge_data = i_rd_word;
    case (i_funct3)
      F3_B:    o_merge_data[{i_addr[1:0], 3'b000} +: 8]  = i_wdata[7:0];
      F3_H:    o_merge_data[{i_addr[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_merge_data = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: turns RV32I byte/half/word accesses into word-only RAM
// cycles, with read-modify-write for sub-word stores and fault reporting.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W
) (
  input  logic      clk,
  input  logic      reset_n,
  lsu_ctrl_if.slave bus
);

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_addr_q;
  logic [31:0] r_wdata_q;
  logic [2:0]  r_funct3_q;
  logic        r_we_q;
  logic [31:0] r_rdata;
  fault_e      r_fault;

  logic        w_idle;
  logic        w_accept;
  logic [31:0] w_sel_addr;
  logic [2:0]  w_sel_funct3;
  logic        w_sel_we;
  fault_e      w_fault;
  logic [31:0] w_load_data;
  logic [31:0] w_merge_data;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && bus.req;

  // In IDLE the live request is decoded (RAM read starts in the accept cycle);
  // afterwards everything works from the latched copy.
  assign w_sel_addr   = w_idle ? bus.addr   : r_addr_q;
  assign w_sel_funct3 = w_idle ? bus.funct3 : r_funct3_q;
  assign w_sel_we     = w_idle ? bus.we     : r_we_q;

  lsu_ctrl_align #(.ADDR_W(ADDR_W)) u_align (
    .i_we         (w_sel_we),
    .i_funct3     (w_sel_funct3),
    .i_addr       (w_sel_addr),
    .i_rd_word    (bus.ram_rd_data),
    .i_wdata      (r_wdata_q),
    .o_fault      (w_fault),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.req) begin
          if (w_fault != FLT_NONE)  w_next = ST_ERR;
          else if (!bus.we)         w_next = ST_LOAD;
          else if (bus.funct3 == F3_W) w_next = ST_SW_WR;
          else                      w_next = ST_RMW;
        end
      end
      ST_LOAD, ST_SW_WR, ST_RMW, ST_ERR: w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state; the RAM write strobe exists only in SW_WR/RMW.
  always_comb begin
    bus.busy        = !w_idle;
    bus.done        = (r_state == ST_DONE);
    bus.ram_addr    = w_sel_addr;
    bus.ram_wr_sig  = 1'b0;
    bus.ram_wr_data = r_wdata_q;
    case (r_state)
      ST_SW_WR: begin
        bus.ram_wr_sig  = 1'b1;
        bus.ram_wr_data = r_wdata_q;
      end
      ST_RMW: begin
        bus.ram_wr_sig  = 1'b1;
        bus.ram_wr_data = w_merge_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr_q   <= '0;
      r_wdata_q  <= '0;
      r_funct3_q <= '0;
      r_we_q     <= 1'b0;
      r_rdata    <= '0;
      r_fault    <= FLT_NONE;
    end else begin
      if (w_accept) begin
        r_addr_q   <= bus.addr;
        r_wdata_q  <= bus.wdata;
        r_funct3_q <= bus.funct3;
        r_we_q     <= bus.we;
      end
      if (r_state == ST_LOAD) r_rdata <= w_load_data;
      if (r_state == ST_ERR)       r_fault <= w_fault;
      else if (r_state == ST_DONE) r_fault <= FLT_NONE;
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.fault = r_fault;

endmodule
